serial_ram_arbiter: RTL and testbench
=====================================

SERIAL_RAM_ARBITER -- requirements
Module: serial_ram_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_PINS, default 4: external RAM address pins.
REQ-002 The module SHALL have parameter DATA_PINS, default 4: external RAM data pins.
REQ-003 The module SHALL have parameter LOG2_CYCLES, default 2: CYCLES = 2**LOG2_CYCLES clocks per frame; AW = ADDR_PINS*CYCLES; DW = DATA_PINS*CYCLES.
REQ-004 The module SHALL have parameter RD_LATENCY, default 7: clocks from frame start to first returned data nibble on data_in.
REQ-005 The module SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-006 The module SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 The module SHALL have ports req_valid, input, 2: per-requester read request.
REQ-008 The module SHALL have ports req_addr0 and req_addr1, input, AW each: read addresses.
REQ-009 The module SHALL have port req_ready, output, 2: per-requester accept strobe.
REQ-010 The module SHALL have port addr_out, output, ADDR_PINS: serial address nibble to RAM.
REQ-011 The module SHALL have port data_in, input, DATA_PINS: serial data nibble from RAM.
REQ-012 The module SHALL have ports rsp_valid (output, 1), rsp_id (output, 1) and rsp_data (output, DW): read response.

Function
REQ-013 The module SHALL run a free-running frame counter, 0..CYCLES-1, that wraps to 0; the counter is 0 in the first cycle after reset deasserts.
REQ-014 Frame start SHALL be the cycle in which the counter equals 0; the boundary cycle SHALL be the cycle in which the counter equals CYCLES-1.
REQ-015 In counter cycle k, addr_out SHALL equal nibble k of the frame's address register, LSB nibble first.
REQ-016 Each frame's address register SHALL be loaded at the end of the preceding boundary cycle: with the accepted address, or with 0 if no request was accepted (idle frame).
REQ-017 req_ready SHALL be combinational and one-hot-or-zero, and SHALL be asserted only in the boundary cycle.
REQ-018 In the boundary cycle, req_ready[i] SHALL be 1 iff requester i is granted; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-019 Arbitration SHALL be as follows:
- Only one port valid: that port is granted.
- Both ports valid: the port not granted most recently is granted.
- After reset: port 0 wins the first tie.
REQ-020 The last-grant pointer SHALL update only on an actual transfer.
REQ-021 For a frame starting in cycle T, data_in nibble j (j = 0..CYCLES-1) SHALL be sampled in cycle T+RD_LATENCY+j and placed in rsp_data bits [DATA_PINS*j +: DATA_PINS].
REQ-022 rsp_valid SHALL pulse for one cycle at T+RD_LATENCY+CYCLES with the complete word in rsp_data and the granted port in rsp_id.
REQ-023 Idle frames SHALL never produce rsp_valid.
REQ-024 Multiple frames SHALL be in flight concurrently: the module SHALL issue a new frame every CYCLES clocks regardless of outstanding reads.
REQ-025 Responses SHALL be returned in issue order, and there SHALL be no response backpressure.
REQ-026 rsp_data and rsp_id SHALL hold their last values while rsp_valid is 0.
REQ-027 Back-to-back transfers in consecutive boundary cycles SHALL yield rsp_valid pulses exactly CYCLES clocks apart.
REQ-028 req_valid deasserted after a transfer SHALL have no effect on the issued frame.

Reset
REQ-029 While reset is high the module SHALL force:
- counter = 0
- addr_out = 0
- req_ready = 0
- rsp_valid = 0
- rsp_id = 0
- rsp_data = 0
- last-grant pointer = port 1, so port 0 wins the first tie
REQ-030 Reset asserted mid-operation SHALL discard all in-flight reads: no rsp_valid for frames issued before reset, and the counter restarts at 0 the cycle after deassertion.

Verification
REQ-031 The bench SHALL cover these directed scenarios (defaults; RAM model preloaded; cycle 0 = first cycle after reset deasserts):
- Single read: RAM[0x0123] = 0xBEEF; port 0 valid, addr 0x0123 -> req_ready[0] = 1 in cycle 3; addr_out = 3,2,1,0 in cycles 4-7; rsp_valid in cycle 15 with rsp_data = 0xBEEF, rsp_id = 0.
- Tie round-robin: both ports valid continuously, addrs 0x0010/0x0020 -> grants alternate 0,1,0,1 in cycles 3,7,11,15; rsp_valid in cycles 15,19,23,27 with rsp_id alternating 0,1 and matching data.
- Single-port streaming: port 1 only, four addrs back-to-back -> four responses exactly 4 clocks apart, in order, no gaps.
- Idle: no valid for 40 cycles -> addr_out = 0 throughout; rsp_valid never asserts; req_ready = 0.
- Reset mid-flight: accept in cycle 3, assert reset in cycles 9-10 -> no rsp_valid before the first new response; counter restarts; a new request in new cycle 3 returns correct data in new cycle 15.
- Pointer-hold: port 1 only granted, then both valid -> port 0 wins the next tie.

Source files
------------

// File: rtl/serial_ram_arbiter.sv
// Two-port read arbiter for a nibble-serial external RAM: one address frame of
// CYCLES clocks is issued back to back, with reads pipelined across frames.
module serial_ram_arbiter #(
  parameter int ADDR_PINS   = 4,
  parameter int DATA_PINS   = 4,
  parameter int LOG2_CYCLES = 2,
  parameter int RD_LATENCY  = 7
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [1:0]                                req_valid,
  input  logic [ADDR_PINS*(2**LOG2_CYCLES)-1:0]     req_addr0,
  input  logic [ADDR_PINS*(2**LOG2_CYCLES)-1:0]     req_addr1,
  output logic [1:0]                                req_ready,
  output logic [ADDR_PINS-1:0]                      addr_out,
  input  logic [DATA_PINS-1:0]                      data_in,
  output logic                                      rsp_valid,
  output logic                                      rsp_id,
  output logic [DATA_PINS*(2**LOG2_CYCLES)-1:0]     rsp_data
);

  localparam int CYCLES = 2 ** LOG2_CYCLES;
  localparam int AW     = ADDR_PINS * CYCLES;
  localparam int DW     = DATA_PINS * CYCLES;
  // pipe stage PIPE_D-1 marks the cycle in which the last data nibble arrives
  localparam int PIPE_D = RD_LATENCY + CYCLES - 1;
  localparam logic [LOG2_CYCLES-1:0] CNT_LAST = LOG2_CYCLES'(CYCLES - 1);

  logic [LOG2_CYCLES-1:0] cnt;
  logic                   boundary;
  logic                   start;
  logic [1:0]             grant;
  logic                   last_grant;
  logic [AW-1:0]          addr_reg;
  logic                   frame_v;
  logic                   frame_id;
  logic [PIPE_D-1:0]      pipe_v;
  logic [PIPE_D-1:0]      pipe_id;
  logic [DW-DATA_PINS-1:0] acc;
  logic [DW-1:0]          acc_next;

  assign boundary = !reset && (cnt == CNT_LAST);
  assign start    = (cnt == '0) && frame_v;

  always_comb begin
    grant = 2'b00;
    if (boundary) begin
      case (req_valid)
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = req_valid;
      endcase
    end
  end

  assign req_ready = grant;
  assign addr_out  = reset ? '0 : addr_reg[ADDR_PINS*int'(cnt) +: ADDR_PINS];

  // incoming nibbles shift in from the top, so nibble 0 ends up lowest
  assign acc_next = {data_in, acc};

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      addr_reg   <= '0;
      frame_v    <= 1'b0;
      frame_id   <= 1'b0;
      last_grant <= 1'b1;
      pipe_v     <= '0;
      pipe_id    <= '0;
      acc        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
    end else begin
      cnt <= cnt + LOG2_CYCLES'(1);
      if (boundary) begin
        frame_v  <= |grant;
        frame_id <= grant[1];
        addr_reg <= grant[1] ? req_addr1 : (grant[0] ? req_addr0 : '0);
        if (|grant) last_grant <= grant[1];
      end
      pipe_v[0]  <= start;
      pipe_id[0] <= frame_id;
      for (int i = 1; i < PIPE_D; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
      acc       <= acc_next[DW-1:DATA_PINS];
      rsp_valid <= pipe_v[PIPE_D-1];
      if (pipe_v[PIPE_D-1]) begin
        rsp_data <= acc_next;
        rsp_id   <= pipe_id[PIPE_D-1];
      end
    end
  end

endmodule

// File: tb/tb_serial_ram_arbiter.sv
// Directed and random bench for serial_ram_arbiter, checked against a
// frame-level model (grants per frame, RAM contents, response schedule).
module tb_serial_ram_arbiter;
  localparam int CYC = 4;
  localparam int LAT = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_addr0 = '0;
  logic [15:0] req_addr1 = '0;
  logic [3:0]  data_in = '0;
  logic [1:0]  req_ready;
  logic [3:0]  addr_out;
  logic        rsp_valid;
  logic        rsp_id;
  logic [15:0] rsp_data;

  serial_ram_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_ready(req_ready),
    .addr_out(addr_out), .data_in(data_in), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int c;
  int last_g;
  int rsp_seen;
  logic [15:0] fa [512];
  bit          fv [512];
  bit          fid [512];
  logic [15:0] exp_data;
  logic        exp_id;

  function automatic logic [15:0] ram_word(input logic [15:0] a);
    if (a == 16'h0123) return 16'hBEEF;
    return 16'((a * 16'h9E37) ^ 16'h5A5A);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, obs, exp);
    end
  endtask

  task automatic model_init();
    c = 0;
    last_g = 1;
    for (int f = 0; f < 512; f++) begin
      fa[f] = '0; fv[f] = 1'b0; fid[f] = 1'b0;
    end
    exp_data = '0;
    exp_id = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    req_valid = 2'b00;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_addr_out", 32'(addr_out), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    end
    reset = 1'b0;
    model_init();
  endtask

  // one clock: drive inputs, check outputs against the frame model, advance
  task automatic step(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] a1);
    int ph, f, ff, j, g;
    logic [15:0] w;
    logic [1:0]  er;
    logic        ev;
    ph = c % CYC;
    f  = c / CYC;
    req_valid = v; req_addr0 = a0; req_addr1 = a1;
    data_in = 4'($urandom);
    if (c >= LAT) begin
      ff = (c - LAT) / CYC;
      j  = (c - LAT) % CYC;
      if (fv[ff]) begin
        w = ram_word(fa[ff]);
        data_in = w[4*j +: 4];
      end
    end
    g = -1;
    if (ph == CYC - 1) begin
      if (v == 2'b11) g = (last_g == 1) ? 0 : 1;
      else if (v == 2'b01) g = 0;
      else if (v == 2'b10) g = 1;
    end
    er = (g == 0) ? 2'b01 : ((g == 1) ? 2'b10 : 2'b00);
    ev = 1'b0;
    if (c >= LAT + CYC && (c - LAT - CYC) % CYC == 0) begin
      ff = (c - LAT - CYC) / CYC;
      if (fv[ff]) begin
        ev = 1'b1;
        exp_data = ram_word(fa[ff]);
        exp_id = fid[ff];
      end
    end
    #1;
    w = fa[f];
    chk("addr_out", 32'(addr_out), 32'(w[4*ph +: 4]));
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("rsp_data", 32'(rsp_data), 32'(exp_data));
    chk("rsp_id", 32'(rsp_id), 32'(exp_id));
    if (rsp_valid) rsp_seen++;
    if (ph == CYC - 1) begin
      fv[f+1]  = (g >= 0);
      fa[f+1]  = (g == 0) ? a0 : ((g == 1) ? a1 : 16'h0000);
      fid[f+1] = (g == 1);
      if (g >= 0) last_g = g;
    end
    @(posedge clk); #1;
    c++;
  endtask

  initial begin
    logic [15:0] stream [4];
    stream[0] = 16'h1111; stream[1] = 16'h2A2B; stream[2] = 16'h3C3D; stream[3] = 16'h4E4F;
    model_init();

    // single read
    do_reset(3);
    rsp_seen = 0;
    for (int i = 0; i < 18; i++) step((c < 4) ? 2'b01 : 2'b00, 16'h0123, 16'h0000);
    chk("single_count", 32'(rsp_seen), 32'd1);

    // tie round-robin
    do_reset(2);
    rsp_seen = 0;
    for (int i = 0; i < 31; i++) step((c < 16) ? 2'b11 : 2'b00, 16'h0010, 16'h0020);
    chk("tie_count", 32'(rsp_seen), 32'd4);

    // single-port streaming on port 1
    do_reset(2);
    rsp_seen = 0;
    for (int i = 0; i < 31; i++)
      step((c < 16) ? 2'b10 : 2'b00, 16'hFFFF, (c < 16) ? stream[c/4] : 16'h0000);
    chk("stream_count", 32'(rsp_seen), 32'd4);

    // idle
    do_reset(2);
    rsp_seen = 0;
    for (int i = 0; i < 40; i++) step(2'b00, 16'($urandom), 16'($urandom));
    chk("idle_count", 32'(rsp_seen), 32'd0);

    // reset while a read is in flight
    do_reset(2);
    rsp_seen = 0;
    for (int i = 0; i < 9; i++) step((c < 4) ? 2'b01 : 2'b00, 16'h0123, 16'h0000);
    do_reset(2);
    for (int i = 0; i < 18; i++) step((c < 4) ? 2'b01 : 2'b00, 16'h0456, 16'h0000);
    chk("midreset_count", 32'(rsp_seen), 32'd1);

    // pointer holds across idle frames
    do_reset(2);
    rsp_seen = 0;
    for (int i = 0; i < 4; i++) step(2'b10, 16'h0AAA, 16'h0BBB);
    for (int i = 0; i < 4; i++) step(2'b00, 16'h0AAA, 16'h0BBB);
    for (int i = 0; i < 4; i++) step(2'b11, 16'h0CCC, 16'h0DDD);
    for (int i = 0; i < 16; i++) step(2'b00, 16'h0000, 16'h0000);
    chk("ptr_count", 32'(rsp_seen), 32'd2);

    // random traffic
    do_reset(2);
    for (int i = 0; i < 400; i++)
      step(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
